// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit. Runs one req/ack data-memory
// transaction at a time, lane-aligns stores and extends loads, stalling until done.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic        i_LL_bit,
  input  logic        i_flush,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_result_valid,
  output logic [31:0] o_result,
  output logic        o_except_valid,
  output logic [4:0]  o_except_cause,
  output logic        o_LL_set,
  output logic        o_LL_clear
);
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SC  = 6'h38;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL: is_load = 1'b1;
      default:                                    is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_SC: is_store = 1'b1;
      default:                    is_store = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH:       misaligned = lo[0];
      OP_LW, OP_LL, OP_SW, OP_SC: misaligned = (lo != 2'b00);
      default:                    misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LB, OP_LBU, OP_SB: lane_be = 4'b0001 << lo;
      OP_LH, OP_LHU, OP_SH: lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default:              lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   lane_wdata = {4{d[7:0]}};
      OP_SH:   lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   load_extend = {{24{b[7]}}, b};
      OP_LBU:  load_extend = {24'd0, b};
      OP_LH:   load_extend = {{16{h[15]}}, h};
      OP_LHU:  load_extend = {16'd0, h};
      default: load_extend = w;
    endcase
  endfunction

  state_t      state_r, state_next_s;
  logic [5:0]  op_r;
  logic [1:0]  lo_r;
  logic [29:0] addr_r;
  logic [31:0] wdata_r, rdata_r;
  logic [3:0]  be_r;
  logic [5:0]  opcode_s;
  logic        accept_s, start_s;
  logic        unused_s;

  assign opcode_s = i_instr[31:26];
  assign unused_s = ^i_instr[25:0];
  // Reset also blocks acceptance so every output reads 0 while resetn is low.
  assign accept_s = resetn & i_valid & ~i_flush & (is_load(opcode_s) | is_store(opcode_s));

  // Next-state and output decode
  always_comb begin
    state_next_s   = state_r;
    start_s        = 1'b0;
    o_dmem_req     = 1'b0;
    o_dmem_we      = 1'b0;
    o_dmem_addr    = 32'd0;
    o_dmem_wdata   = 32'd0;
    o_dmem_be      = 4'd0;
    o_stall        = 1'b0;
    o_result_valid = 1'b0;
    o_result       = 32'd0;
    o_except_valid = 1'b0;
    o_except_cause = 5'd0;
    o_LL_set       = 1'b0;
    o_LL_clear     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_next_s = IDLE;
        end else if (misaligned(opcode_s, i_addr[1:0])) begin
          o_except_valid = 1'b1;
          o_except_cause = is_load(opcode_s) ? 5'd4 : 5'd5;
        end else if ((opcode_s == OP_SC) && !i_LL_bit) begin
          o_result_valid = 1'b1;
          o_LL_clear     = 1'b1;
        end else begin
          o_stall      = 1'b1;
          start_s      = 1'b1;
          state_next_s = REQ;
        end
      end
      REQ, DRAIN: begin
        // A request once raised is held until acked, even across a flush.
        o_dmem_req   = 1'b1;
        o_stall      = 1'b1;
        o_dmem_we    = is_store(op_r);
        o_dmem_addr  = {addr_r, 2'b00};
        o_dmem_wdata = wdata_r;
        o_dmem_be    = be_r;
        if (i_dmem_ack) begin
          state_next_s = ((state_r == REQ) && !i_flush) ? DONE : IDLE;
        end else if (i_flush) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE: begin
        state_next_s = IDLE;
        if (i_flush) begin
          o_result_valid = 1'b0;
        end else if (op_r == OP_SC) begin
          o_result_valid = 1'b1;
          o_result       = 32'd1;
          o_LL_clear     = 1'b1;
        end else if (is_load(op_r)) begin
          o_result_valid = 1'b1;
          o_result       = rdata_r;
          o_LL_set       = (op_r == OP_LL);
        end else begin
          o_result_valid = 1'b0;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register, transaction latch and load-data capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      op_r    <= 6'd0;
      lo_r    <= 2'd0;
      addr_r  <= 30'd0;
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
      rdata_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (start_s) begin
        op_r    <= opcode_s;
        lo_r    <= i_addr[1:0];
        addr_r  <= i_addr[31:2];
        wdata_r <= lane_wdata(opcode_s, i_store_data);
        be_r    <= lane_be(opcode_s, i_addr[1:0]);
      end
      if ((state_r == REQ) && i_dmem_ack) begin
        rdata_r <= load_extend(op_r, lo_r, i_dmem_rdata);
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and random transactions against an arithmetic
// reference model of lane selection, extension and transaction timing.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_instr = 32'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_store_data = 32'd0;
  logic        i_LL_bit = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_dmem_ack = 1'b0;
  logic [31:0] i_dmem_rdata = 32'd0;
  logic        o_dmem_req, o_dmem_we, o_stall, o_result_valid, o_except_valid;
  logic        o_LL_set, o_LL_clear;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_result;
  logic [3:0]  o_dmem_be;
  logic [4:0]  o_except_cause;
  int          checks = 0;
  int          errors = 0;

  mem_stage_lsu dut (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .i_instr(i_instr), .i_addr(i_addr),
    .i_store_data(i_store_data), .i_LL_bit(i_LL_bit), .i_flush(i_flush),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall), .o_result_valid(o_result_valid),
    .o_result(o_result), .o_except_valid(o_except_valid), .o_except_cause(o_except_cause),
    .o_LL_set(o_LL_set), .o_LL_clear(o_LL_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; 0 means not a memory instruction.
  function automatic int unsigned op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28:        return 1;
      6'h21, 6'h25, 6'h29:        return 2;
      6'h23, 6'h30, 6'h2B, 6'h38: return 4;
      default:                    return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B) || (op == 6'h38);
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned lane, b, h;
    lane = addr % 4;
    b = (rd >> (8 * lane)) % 256;
    h = (rd >> (16 * (lane / 2))) % 65536;
    case (op)
      6'h20:   return (b >= 128) ? b - 256 : b;
      6'h24:   return b;
      6'h21:   return (h >= 32768) ? h - 65536 : h;
      6'h25:   return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input int unsigned sz, input logic [31:0] addr);
    int unsigned lane;
    lane = addr % 4;
    if (sz == 1) return 4'(1 << lane);
    if (sz == 2) return 4'(3 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input int unsigned sz, input logic [31:0] d);
    if (sz == 1) return (d % 256) * 32'h01010101;
    if (sz == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".req"}, 32'(o_dmem_req), 32'd0);
    check({tag, ".stall"}, 32'(o_stall), 32'd0);
    check({tag, ".rv"}, 32'(o_result_valid), 32'd0);
    check({tag, ".exc"}, {26'd0, o_except_valid, o_except_cause}, 32'd0);
    check({tag, ".ll"}, {30'd0, o_LL_set, o_LL_clear}, 32'd0);
    check({tag, ".we_be"}, {27'd0, o_dmem_we, o_dmem_be}, 32'd0);
  endtask

  // One instruction from MEM entry to retirement; called just after a rising edge.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic ll, input logic [31:0] rd,
                        input int wait_n, input int flush_at, input bit flush_done);
    int unsigned sz;
    bit st, mis, scfail, flushed;
    sz = op_size(op);
    st = op_store(op);
    mis = (sz != 0) && (addr % sz != 0);
    scfail = (op == 6'h38) && !ll && !mis;
    i_valid = 1'b1; i_instr = {op, 26'($urandom)}; i_addr = addr; i_store_data = sd;
    i_LL_bit = ll; i_flush = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
    @(negedge clk);
    if (sz == 0 || mis || scfail) begin
      check({tag, ".n.req"}, 32'(o_dmem_req), 32'd0);
      check({tag, ".n.stall"}, 32'(o_stall), 32'd0);
      check({tag, ".n.exc"}, 32'(o_except_valid), 32'(mis));
      check({tag, ".n.cause"}, 32'(o_except_cause), mis ? (st ? 32'd5 : 32'd4) : 32'd0);
      check({tag, ".n.rv"}, 32'(o_result_valid), 32'(scfail));
      if (scfail) check({tag, ".n.res"}, o_result, 32'd0);
      check({tag, ".n.ll"}, {30'd0, o_LL_set, o_LL_clear}, 32'(scfail));
      @(posedge clk); #1;
      i_valid = 1'b0;
      return;
    end
    check({tag, ".n.stall"}, 32'(o_stall), 32'd1);
    check({tag, ".n.req"}, 32'(o_dmem_req), 32'd0);
    check({tag, ".n.exc"}, 32'(o_except_valid), 32'd0);
    @(posedge clk); #1;
    // Scramble the MEM inputs so only latched values can produce correct lanes.
    i_instr = $urandom; i_addr = $urandom; i_store_data = $urandom;
    flushed = 1'b0;
    for (int c = 0; c <= wait_n; c++) begin
      i_flush = (c == flush_at);
      if (c == flush_at) flushed = 1'b1;
      i_dmem_ack = (c == wait_n);
      i_dmem_rdata = (c == wait_n) ? rd : $urandom;
      @(negedge clk);
      check({tag, ".r.req"}, 32'(o_dmem_req), 32'd1);
      check({tag, ".r.stall"}, 32'(o_stall), 32'd1);
      check({tag, ".r.we"}, 32'(o_dmem_we), 32'(st));
      check({tag, ".r.addr"}, o_dmem_addr, addr - addr % 4);
      check({tag, ".r.be"}, 32'(o_dmem_be), 32'(exp_be(sz, addr)));
      if (st) check({tag, ".r.wdata"}, o_dmem_wdata, exp_wdata(sz, sd));
      check({tag, ".r.rv"}, 32'(o_result_valid), 32'd0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_dmem_ack = 1'b0;
    i_flush = flush_done && !flushed;
    @(negedge clk);
    check({tag, ".d.stall"}, 32'(o_stall), 32'd0);
    check({tag, ".d.req"}, 32'(o_dmem_req), 32'd0);
    if (!flushed && !flush_done) begin
      check({tag, ".d.rv"}, 32'(o_result_valid), 32'(!st || op == 6'h38));
      if (op == 6'h38) check({tag, ".d.res"}, o_result, 32'd1);
      else if (!st) check({tag, ".d.res"}, o_result, exp_load(op, addr, rd));
      check({tag, ".d.llset"}, 32'(o_LL_set), 32'(op == 6'h30));
      check({tag, ".d.llclr"}, 32'(o_LL_clear), 32'(op == 6'h38));
    end else begin
      check({tag, ".d.rv"}, 32'(o_result_valid), 32'd0);
      check({tag, ".d.ll"}, {30'd0, o_LL_set, o_LL_clear}, 32'd0);
    end
    @(posedge clk); #1;
    i_flush = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0]  ops [11];
    logic [5:0]  op;
    logic [31:0] a;
    int unsigned sz;
    int          w, fa;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h30, 6'h28, 6'h29, 6'h2B, 6'h38, 6'h22};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    resetn = 1'b1;

    run_op("lw_100",   6'h23, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 0, -1, 1'b0);
    run_op("lb_103",   6'h20, 32'h103, 32'h0, 1'b0, 32'h80112233, 0, -1, 1'b0);
    run_op("lbu_103",  6'h24, 32'h103, 32'h0, 1'b0, 32'h80112233, 1, -1, 1'b0);
    run_op("lhu_102",  6'h25, 32'h102, 32'h0, 1'b0, 32'h80112233, 0, -1, 1'b0);
    run_op("lh_102",   6'h21, 32'h102, 32'h0, 1'b0, 32'h80112233, 2, -1, 1'b0);
    run_op("sh_102",   6'h29, 32'h102, 32'h0000ABCD, 1'b0, 32'h0, 0, -1, 1'b0);
    run_op("sb_101",   6'h28, 32'h101, 32'h123456C7, 1'b0, 32'h0, 1, -1, 1'b0);
    run_op("lw_101",   6'h23, 32'h101, 32'h0, 1'b0, 32'h0, 0, -1, 1'b0);
    run_op("sw_102",   6'h2B, 32'h102, 32'h0, 1'b0, 32'h0, 0, -1, 1'b0);
    run_op("sh_odd",   6'h29, 32'h103, 32'h0, 1'b0, 32'h0, 0, -1, 1'b0);
    run_op("sc_ll0",   6'h38, 32'h200, 32'h5, 1'b0, 32'h0, 0, -1, 1'b0);
    run_op("sc_ll1",   6'h38, 32'h200, 32'h5, 1'b1, 32'h0, 1, -1, 1'b0);
    run_op("ll_ok",    6'h30, 32'h204, 32'h0, 1'b0, 32'hCAFEF00D, 0, -1, 1'b0);
    run_op("lw_drain", 6'h23, 32'h100, 32'h0, 1'b0, 32'h11111111, 3, 0, 1'b0);
    run_op("lw_flack", 6'h23, 32'h104, 32'h0, 1'b0, 32'h22222222, 1, 1, 1'b0);
    run_op("ll_fdone", 6'h30, 32'h208, 32'h0, 1'b0, 32'h33333333, 0, -1, 1'b1);
    run_op("nonmem",   6'h22, 32'h101, 32'h0, 1'b0, 32'h0, 0, -1, 1'b0);

    // Idle-side gating: no valid, then flush alongside a memory op
    i_valid = 1'b0; i_instr = {6'h23, 26'd0}; i_addr = 32'h101;
    @(negedge clk); check_quiet("novalid");
    @(posedge clk); #1;
    i_valid = 1'b1; i_flush = 1'b1;
    @(negedge clk); check_quiet("flush_idle");
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;

    // Reset in the middle of a transaction
    i_valid = 1'b1; i_instr = {6'h23, 26'd0}; i_addr = 32'h300;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk); check("rst_mid.pre_req", 32'(o_dmem_req), 32'd1);
    #1 resetn = 1'b0;
    #1 check_quiet("rst_mid.in");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk); check_quiet("rst_mid.after");
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 10)];
      sz = op_size(op);
      a = $urandom;
      if (sz != 0 && $urandom_range(0, 2) != 0) a = a - a % sz;
      w = $urandom_range(0, 3);
      fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, w) : -1;
      run_op($sformatf("rnd%0d", n), op, a, $urandom, 1'($urandom_range(0, 1)),
             $urandom, w, fa, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
